// File: rtl/pixel_streamer_if.sv
// pixel_streamer_if: frame configuration, row-memory read port and pixel
// column stream of pixel_streamer. The master modport is the streamer side,
// the slave modport is the surrounding system (memory + consumer).
interface pixel_streamer_if #(
    parameter int BUF_HEIGHT = 8,
    parameter int BUF_WIDTH  = 34,
    parameter int ADDR_W     = 8
);
    localparam int WW = $clog2(BUF_WIDTH);
    localparam int SW = $clog2(BUF_HEIGHT) + 1;

    logic                  start;
    logic [ADDR_W-1:0]     base_addr;
    logic [ADDR_W-1:0]     img_height;
    logic [WW-1:0]         img_width;
    logic [SW-1:0]         row_step;
    logic                  stall;

    logic                  mem_rd_en;
    logic [ADDR_W-1:0]     mem_addr;
    logic [BUF_WIDTH-1:0]  mem_rdata;

    logic [BUF_HEIGHT-1:0] pixel_col;
    logic                  shift_enable;
    logic                  band_last;
    logic                  done;
    logic                  busy;
    logic                  cfg_err;

    modport master (
        input  start, base_addr, img_height, img_width, row_step, stall, mem_rdata,
        output mem_rd_en, mem_addr, pixel_col, shift_enable, band_last, done, busy, cfg_err
    );

    modport slave (
        output start, base_addr, img_height, img_width, row_step, stall, mem_rdata,
        input  mem_rd_en, mem_addr, pixel_col, shift_enable, band_last, done, busy, cfg_err
    );
endinterface

// File: rtl/pixel_streamer.sv
// pixel_streamer: loads BUF_HEIGHT image rows into a band buffer, then streams
// the band column by column (one bit per band row) to a downstream line buffer,
// advancing the band by row_step rows until the image height is covered.
// Optional build macro STREAMER_ZERO_PAD_EN: rows at or beyond img_height are
// not read from memory and load as zero.

// One band row: holds a memory word and presents the bit at the current column.
module pixel_streamer_row #(
    parameter int BUF_WIDTH = 34,
    parameter int CW        = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cap_en,
    input  logic [BUF_WIDTH-1:0] cap_data,
    input  logic [CW-1:0]        col,
    output logic                 pix
);
    logic [BUF_WIDTH-1:0] row_q;

    // Capture the returning memory word when this row's load slot comes up.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        row_q <= '0;
        else if (cap_en) row_q <= cap_data;
    end

    assign pix = row_q[col];
endmodule

module pixel_streamer #(
    parameter int BUF_HEIGHT = 8,
    parameter int BUF_WIDTH  = 34,
    parameter int ADDR_W     = 8
) (
    input logic              clk,
    input logic              rst,
    pixel_streamer_if.master bus
);
    localparam int WW = $clog2(BUF_WIDTH);
    localparam int SW = $clog2(BUF_HEIGHT) + 1;
    localparam int RW = (BUF_HEIGHT > 1) ? $clog2(BUF_HEIGHT) : 1;

    localparam logic [WW:0]     MIN_W    = (WW+1)'(4);
    localparam logic [WW:0]     MAX_W    = (WW+1)'(BUF_WIDTH);
    localparam logic [SW-1:0]   MAX_S    = SW'(BUF_HEIGHT);
    localparam logic [ADDR_W:0] BAND_H   = (ADDR_W+1)'(BUF_HEIGHT);
    localparam logic [RW-1:0]   LAST_ROW = RW'(BUF_HEIGHT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, LAST, STREAM, DONE} state_t;

    state_t              state;
    logic                armed;       // low for the first cycle out of reset
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W-1:0]   height_q;
    logic [WW-1:0]       width_q;
    logic [SW-1:0]       step_q;
    logic [ADDR_W-1:0]   band_start;
    logic [RW-1:0]       row;         // row index of the read currently on the bus
    logic [WW-1:0]       col;
    logic                rd_q;        // previous cycle issued a real read
    logic                mem_rd_en_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                cfg_err_q;

    logic                cfg_bad;
    logic                start_ok;
    logic                col_end;
    logic                last_band;
    logic                rd_go;
    logic                rd_ok;
    logic [ADDR_W-1:0]   nxt_base;
    logic [ADDR_W-1:0]   nxt_bs;
    logic [RW-1:0]       nxt_row;
    logic [RW-1:0]       cap_row;
    logic                cap_any;
    logic [BUF_WIDTH-1:0] cap_data;
    logic [BUF_HEIGHT-1:0] pix;

    assign cfg_bad = ({1'b0, bus.img_width} < MIN_W) || ({1'b0, bus.img_width} > MAX_W) ||
                     (bus.row_step == '0) || (bus.row_step > MAX_S) || (bus.img_height == '0);
    assign start_ok  = bus.start && armed && (state == IDLE || state == DONE);
    assign col_end   = (col == width_q - WW'(1));
    // Widened so a band near the top of the address range cannot wrap.
    assign last_band = ({1'b0, band_start} + BAND_H) >= {1'b0, height_q};

    // Next read request: first row of a new band, or the next row of this one.
    always_comb begin
        rd_go    = 1'b0;
        nxt_base = base_q;
        nxt_bs   = band_start;
        nxt_row  = row + RW'(1);
        case (state)
            IDLE, DONE: begin
                if (start_ok && !cfg_bad) begin
                    rd_go    = 1'b1;
                    nxt_base = bus.base_addr;
                    nxt_bs   = '0;
                    nxt_row  = '0;
                end
            end
            LOAD: rd_go = (row != LAST_ROW);
            STREAM: begin
                if (!bus.stall && col_end && !last_band) begin
                    rd_go   = 1'b1;
                    nxt_bs  = band_start + ADDR_W'(step_q);
                    nxt_row = '0;
                end
            end
            default: ;
        endcase
    end

`ifdef STREAMER_ZERO_PAD_EN
    assign rd_ok = ({1'b0, nxt_bs} + (ADDR_W+1)'(nxt_row)) <
                   {1'b0, (start_ok ? bus.img_height : height_q)};
`else
    assign rd_ok = 1'b1;
`endif

    // Frame sequencing: accept/reject start, walk LOAD rows, stream columns, advance bands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            armed       <= 1'b0;
            base_q      <= '0;
            height_q    <= '0;
            width_q     <= '0;
            step_q      <= '0;
            band_start  <= '0;
            row         <= '0;
            col         <= '0;
            rd_q        <= 1'b0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            cfg_err_q   <= 1'b0;
        end else begin
            armed       <= 1'b1;
            cfg_err_q   <= 1'b0;
            rd_q        <= mem_rd_en_q;
            mem_rd_en_q <= rd_go && rd_ok;
            if (rd_go) begin
                mem_addr_q <= nxt_base + nxt_bs + ADDR_W'(nxt_row);
                row        <= nxt_row;
            end
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        if (cfg_bad) begin
                            cfg_err_q <= 1'b1;
                        end else begin
                            base_q     <= bus.base_addr;
                            height_q   <= bus.img_height;
                            width_q    <= bus.img_width;
                            step_q     <= bus.row_step;
                            band_start <= '0;
                            state      <= LOAD;
                        end
                    end
                end
                LOAD: if (row == LAST_ROW) state <= LAST;
                LAST: begin
                    col   <= '0;
                    state <= STREAM;
                end
                STREAM: begin
                    if (!bus.stall) begin
                        if (col_end) begin
                            if (last_band) begin
                                state <= DONE;
                            end else begin
                                band_start <= nxt_bs;
                                state      <= LOAD;
                            end
                        end else begin
                            col <= col + WW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data for row r arrives the cycle after its read; LAST takes the final row.
    assign cap_row  = (state == LAST) ? row : row - RW'(1);
    assign cap_any  = (state == LOAD && row != '0) || (state == LAST);
    assign cap_data = rd_q ? bus.mem_rdata : '0;

    for (genvar r = 0; r < BUF_HEIGHT; r++) begin : g_row
        pixel_streamer_row #(
            .BUF_WIDTH (BUF_WIDTH),
            .CW        (WW)
        ) u_row (
            .clk      (clk),
            .rst      (rst),
            .cap_en   (cap_any && (cap_row == RW'(r))),
            .cap_data (cap_data),
            .col      (col),
            .pix      (pix[r])
        );
    end

    assign bus.mem_rd_en    = mem_rd_en_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.cfg_err      = cfg_err_q;
    assign bus.pixel_col    = (state == STREAM) ? pix : '0;
    assign bus.shift_enable = (state == STREAM) && !bus.stall;
    assign bus.band_last    = (state == STREAM) && last_band;
    assign bus.done         = (state == DONE);
    assign bus.busy         = (state == LOAD) || (state == LAST) || (state == STREAM);
endmodule

// File: tb/tb_pixel_streamer.sv
// tb_pixel_streamer: scoreboard bench. Each accepted start pushes the expected
// read addresses and pixel columns (with band_last) computed from the memory
// image; a negedge monitor pops and compares as the DUT produces them.
`timescale 1ns/1ps
module tb_pixel_streamer;
    localparam int H  = 8;
    localparam int W  = 34;
    localparam int AW = 8;
`ifdef STREAMER_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pixel_streamer_if #(.BUF_HEIGHT(H), .BUF_WIDTH(W), .ADDR_W(AW)) bus();

    pixel_streamer #(.BUF_HEIGHT(H), .BUF_WIDTH(W), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [W-1:0]  mem [256];
    logic [AW-1:0] rdq[$];
    logic [H:0]    pxq[$];
    int n_assert = 0;
    int n_fail   = 0;
    int n_rd     = 0;
    int n_px     = 0;
    int n_last   = 0;
    bit mon_en   = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Synchronous row memory: word appears the cycle after the read strobe.
    always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];

    // Scoreboard monitor: compare reads and streamed columns against the model.
    always @(negedge clk) begin
        logic [H:0] e;
        if (mon_en) begin
            if (bus.mem_rd_en) begin
                n_rd++;
                check("rd_pending", rdq.size() > 0, 1);
                if (rdq.size() > 0) check("rd_addr", bus.mem_addr, rdq.pop_front());
            end
            if (bus.shift_enable) begin
                n_px++;
                if (bus.band_last) n_last++;
                check("px_pending", pxq.size() > 0, 1);
                if (pxq.size() > 0) begin
                    e = pxq.pop_front();
                    check("pixel_col", bus.pixel_col, e[H-1:0]);
                    check("band_last", bus.band_last, e[H]);
                end
            end
        end
    end

    task automatic push_frame(input logic [AW-1:0] base, input int h, input int w, input int step);
        logic [W-1:0]  band [H];
        logic [AW-1:0] a;
        logic [H-1:0]  pc;
        bit last;
        int bs = 0;
        forever begin
            for (int r = 0; r < H; r++) begin
                if (PAD && (bs + r) >= h) begin
                    band[r] = '0;
                end else begin
                    a = AW'(int'(base) + bs + r);
                    rdq.push_back(a);
                    band[r] = mem[a];
                end
            end
            last = (bs + H) >= h;
            for (int c = 0; c < w; c++) begin
                for (int r = 0; r < H; r++) pc[r] = band[r][c];
                pxq.push_back({last, pc});
            end
            if (last) break;
            bs += step;
        end
    endtask

    task automatic do_start(input logic [AW-1:0] base, input int h, input int w, input int step,
                            input bit exp_ok);
        @(posedge clk); #1;
        bus.base_addr  = base;
        bus.img_height = AW'(h);
        bus.img_width  = 6'(w);
        bus.row_step   = 4'(step);
        bus.start      = 1'b1;
        if (exp_ok) push_frame(base, h, w, step);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.done) break;
        end
        check(tag, bus.done, 1);
        check("busy_in_done", bus.busy, 0);
        check("rdq_drained", rdq.size(), 0);
        check("pxq_drained", pxq.size(), 0);
    endtask

    task automatic wait_shifts(input int n);
        int cnt = 0;
        for (int i = 0; i < 2000 && cnt < n; i++) begin
            @(negedge clk);
            if (bus.shift_enable) cnt++;
        end
        check("shift_budget", cnt, n);
    endtask

    function automatic logic [63:0] outs();
        return {bus.mem_rd_en, bus.mem_addr, bus.pixel_col, bus.shift_enable,
                bus.band_last, bus.done, bus.busy, bus.cfg_err};
    endfunction

    initial begin
        logic [63:0] t;
        logic [H:0]  fz;
        int bad [5][3] = '{'{8, 3, 1}, '{8, 8, 0}, '{8, 35, 1}, '{8, 8, 9}, '{0, 8, 1}};
        for (int a = 0; a < 256; a++) begin
            t = {$urandom(), $urandom()};
            mem[a] = t[W-1:0];
        end
        bus.start = 1'b0; bus.base_addr = '0; bus.img_height = '0; bus.img_width = '0;
        bus.row_step = '0; bus.stall = 1'b0; bus.mem_rdata = '0;

        // Reset state, then a start in the first cycle out of reset is ignored.
        repeat (3) @(negedge clk);
        check("reset_outs", outs(), 0);
        mon_en = 1'b1;
        bus.base_addr = 8'h10; bus.img_height = 8; bus.img_width = 8; bus.row_step = 1;
        bus.start = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("first_cycle_start_busy", bus.busy, 0);
        repeat (3) @(negedge clk);
        check("first_cycle_start_idle", bus.busy, 0);

        // Single band: 8x8, step 1.
        n_px = 0; n_rd = 0;
        do_start(8'h10, 8, 8, 1, 1);
        wait_done("done_8x8");
        check("px_8x8", n_px, 8);
        check("rd_8x8", n_rd, 8);

        // Three bands, with a start while busy that must be ignored.
        n_px = 0; n_last = 0;
        do_start(8'h20, 10, 8, 1, 1);
        repeat (5) @(posedge clk);
        do_start(8'h80, 8, 8, 1, 0);
        wait_done("done_h10");
        check("px_h10", n_px, 24);
        check("last_h10", n_last, 8);

        // Stall for three cycles at column 4.
        n_px = 0;
        do_start(8'h30, 8, 8, 1, 1);
        wait_shifts(4);
        @(posedge clk); #1;
        bus.stall = 1'b1;
        fz = pxq[0];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_se", bus.shift_enable, 0);
            check("stall_pc", bus.pixel_col, fz[H-1:0]);
        end
        @(posedge clk); #1;
        bus.stall = 1'b0;
        wait_done("done_stall");
        check("px_stall", n_px, 8);

        // Rejected configurations from DONE: pulse cfg_err, stay DONE, no reads.
        for (int k = 0; k < 5; k++) begin
            do_start(8'h40, bad[k][0], bad[k][1], bad[k][2], 0);
            check("cfg_err_pulse", bus.cfg_err, 1);
            check("cfg_err_done", bus.done, 1);
            check("cfg_err_busy", bus.busy, 0);
            @(posedge clk); #1;
            check("cfg_err_clear", bus.cfg_err, 0);
        end

        // Asynchronous reset during band 1, then restart from band 0.
        do_start(8'h40, 10, 8, 1, 1);
        wait_shifts(10);
        #2;
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        check("async_rst_outs", outs(), 0);
        rdq.delete();
        pxq.delete();
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        do_start(8'h40, 8, 3, 1, 0);
        check("cfg_err_idle", bus.cfg_err, 1);
        check("cfg_err_idle_done", bus.done, 0);
        check("cfg_err_idle_busy", bus.busy, 0);
        do_start(8'h50, 8, 8, 1, 1);
        wait_done("done_after_rst");

        // Short image: zero-padded rows are not read.
        n_rd = 0;
        do_start(8'h60, 5, 8, 1, 1);
        wait_done("done_h5");
        check("rd_h5", n_rd, PAD ? 5 : 8);

        // Full width with address wrap, and a multi-band run with step 4.
        do_start(8'hFC, 8, 34, 1, 1);
        wait_done("done_wrap");
        n_px = 0;
        do_start(8'h90, 20, 6, 4, 1);
        wait_done("done_step4");
        check("px_step4", n_px, 24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/pixel_streamer.md
PIXEL_STREAMER -- requirements
Module: pixel_streamer

Interface
REQ-001 SHALL have parameter BUF_HEIGHT, default 8: rows per band, equal to the line-buffer height.
REQ-002 SHALL have parameter BUF_WIDTH, default 34: maximum image width in pixels, equal to the memory word width.
REQ-003 SHALL have parameter ADDR_W, default 8: width of the row address and of the image height.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: one-cycle pulse that begins a frame.
REQ-007 SHALL have port base_addr, input, ADDR_W bits: memory address of image row 0.
REQ-008 SHALL have port img_height, input, ADDR_W bits: image height in rows.
REQ-009 SHALL have port img_width, input, $clog2(BUF_WIDTH) bits: image width in pixels.
REQ-010 SHALL have port row_step, input, $clog2(BUF_HEIGHT)+1 bits: band advance in rows, 1..BUF_HEIGHT.
REQ-011 SHALL have port stall, input, 1 bit: downstream not ready.
REQ-012 SHALL have port mem_rd_en, output, 1 bit: row read strobe.
REQ-013 SHALL have port mem_addr, output, ADDR_W bits: row read address.
REQ-014 SHALL have port mem_rdata, input, BUF_WIDTH bits: row word; bit k = pixel column k.
REQ-015 SHALL have port pixel_col, output, BUF_HEIGHT bits: bit r = band row r at the current column.
REQ-016 SHALL have port shift_enable, output, 1 bit: pixel_col valid; line buffer shifts.
REQ-017 SHALL have port band_last, output, 1 bit: high while the final band of the frame streams.
REQ-018 SHALL have port done, output, 1 bit: frame complete.
REQ-019 SHALL have port busy, output, 1 bit: FSM not IDLE/DONE.
REQ-020 SHALL have port cfg_err, output, 1 bit: one-cycle pulse on a rejected start.

Function
REQ-021 SHALL implement states IDLE, LOAD, LAST, STREAM, DONE.
REQ-022 SHALL, on start in IDLE or DONE, latch base_addr, img_height, img_width and row_step, clear done, set band_start=0 and go to LOAD.
REQ-023 SHALL reject start when img_width<4, img_width>BUF_WIDTH, row_step==0, row_step>BUF_HEIGHT or img_height==0: pulse cfg_err for one cycle and leave state unchanged.
REQ-024 SHALL ignore start while busy.
REQ-025 SHALL, in LOAD, issue BUF_HEIGHT consecutive reads (mem_rd_en=1, mem_addr=base+band_start+r, r=0..BUF_HEIGHT-1), one per cycle.
REQ-026 SHALL capture mem_rdata one cycle after each read into band row r; LAST captures the final row and then enters STREAM.
REQ-027 SHALL, in STREAM, drive pixel_col[r]=band[r][col] with shift_enable=1 for col=0..img_width-1, one column per non-stalled cycle.
REQ-028 SHALL, while stall=1, drive shift_enable=0 and hold col, pixel_col and state.
REQ-029 SHALL, after col=img_width-1: if band_start+BUF_HEIGHT>=img_height go to DONE; else band_start+=row_step and go to LOAD.
REQ-030 SHALL compute band_start+BUF_HEIGHT at ADDR_W+1 bits so no wrap occurs; mem_addr wraps modulo 2^ADDR_W.
REQ-031 SHALL hold done=1 in DONE until the next accepted start; shift_enable=0 outside STREAM.
REQ-032 SHALL assert band_last throughout STREAM of the final band.

Reset
REQ-033 SHALL, on rst low, immediately enter IDLE and clear band_start, col, band registers, pixel_col, shift_enable, mem_rd_en, mem_addr, band_last, done, busy and cfg_err to 0, including mid-frame.
REQ-034 SHALL ignore start in the first cycle after rst deasserts.

Configuration
REQ-035 SHALL, with STREAMER_ZERO_PAD_EN defined, suppress reads of rows at or beyond img_height and load those band rows as 0.
REQ-036 SHALL, without STREAMER_ZERO_PAD_EN, read every band row from memory regardless of img_height.

Verification
REQ-037 SHALL cover: width=8, height=8, step=1 -> one LOAD of rows 0-7, 8 shift_enable cycles, pixel_col=column bits, then done=1.
REQ-038 SHALL cover: height=10, step=1 -> bands start at rows 0, 1 and 2; band_last high only on band 2; 3x8 columns streamed.
REQ-039 SHALL cover: stall high for 3 cycles at col=4 -> shift_enable low and pixel_col frozen for 3 cycles; 8 columns total.
REQ-040 SHALL cover: start with img_width=3 or row_step=0 -> cfg_err pulse, state stays IDLE, no mem_rd_en.
REQ-041 SHALL cover: rst low during STREAM of band 1 -> all outputs 0 asynchronously; a fresh start then restarts at band_start=0.
REQ-042 SHALL cover: height=5 with STREAMER_ZERO_PAD_EN -> exactly 5 reads and pixel_col[7:5]=0; without the macro -> 8 reads.
